// File: rtl/vga_pkg.sv
// Shared VGA definitions: visible-area defaults, pattern modes and colour constants.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    BARS     = 2'd0,
    GRADIENT = 2'd1,
    CHECKER  = 2'd2,
    BOX      = 2'd3
  } mode_t;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;
  localparam logic [23:0] COL_BOX_BG  = 24'h000040;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      BARS:     return GRADIENT;
      GRADIENT: return CHECKER;
      CHECKER:  return BOX;
      default:  return BARS;
    endcase
  endfunction

  // Standard colour-bar order, left to right
  function automatic logic [23:0] bar_colour(input logic [2:0] k);
    case (k)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel-coordinate in / colour out bundle between the timing source and the pattern generator.
interface vga_pattern_gen_if;

  logic       pixel_en;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       frame_start;
  logic       mode_next;
  logic [7:0] R;
  logic [7:0] G;
  logic [7:0] B;
  logic       valid;
  logic [1:0] mode;

  modport master (
    output pixel_en, x, y, active, frame_start, mode_next,
    input  R, G, B, valid, mode
  );

  modport slave (
    input  pixel_en, x, y, active, frame_start, mode_next,
    output R, G, B, valid, mode
  );

endinterface

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing box: steps by STEP per frame, saturating at 0 and LIMIT and reversing there.
module vga_bounce_axis #(
  parameter int LIMIT = 608,
  parameter int STEP  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       step,
  output logic [9:0] pos
);

  localparam logic [10:0] LIMIT_W = 11'(LIMIT);
  localparam logic [10:0] STEP_W  = 11'(STEP);

  // dir high means moving towards LIMIT
  logic        dir;
  logic [10:0] pos_ext;

  assign pos_ext = {1'b0, pos};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos <= '0;
      dir <= 1'b1;
    end else if (step) begin
      if (dir) begin
        if (pos_ext + STEP_W >= LIMIT_W) begin
          pos <= LIMIT_W[9:0];
          dir <= 1'b0;
        end else begin
          pos <= pos + STEP_W[9:0];
        end
      end else begin
        if (pos_ext <= STEP_W) begin
          pos <= '0;
          dir <= 1'b1;
        end else begin
          pos <= pos - STEP_W[9:0];
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Bring-up test-pattern source for the VGA output path: four selectable patterns, two-strobe latency.
module vga_pattern_gen #(
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int BOX_SIZE   = 32,
  parameter int BOX_STEP   = 2,
  parameter int CHECK_LOG2 = 5
) (
  input  logic               clock,
  input  logic               reset,
  vga_pattern_gen_if.slave   bus
);

  import vga_pkg::*;

  mode_t       mode_q;
  logic        pending;
  logic [9:0]  box_x;
  logic [9:0]  box_y;

  logic [2:0]  bar_idx;
  logic        box_hit;
  logic [10:0] x_ext;
  logic [10:0] y_ext;

  logic [9:0]  s1_x;
  logic [9:0]  s1_y;
  logic        s1_active;
  mode_t       s1_mode;
  logic [2:0]  s1_bar;
  logic        s1_check;
  logic        s1_hit;

  logic [23:0] colour;
  logic [7:0]  r_q;
  logic [7:0]  g_q;
  logic [7:0]  b_q;
  logic        valid_q;

  // Presses are latched until the frame boundary so the mode only ever moves one step per frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q  <= BARS;
      pending <= 1'b0;
    end else if (bus.frame_start && (pending || bus.mode_next)) begin
      mode_q  <= next_mode(mode_q);
      pending <= 1'b0;
    end else if (bus.mode_next) begin
      pending <= 1'b1;
    end
  end

  vga_bounce_axis #(.LIMIT(H_ACTIVE - BOX_SIZE), .STEP(BOX_STEP)) u_axis_x (
    .clock (clock),
    .reset (reset),
    .step  (bus.frame_start),
    .pos   (box_x)
  );

  vga_bounce_axis #(.LIMIT(V_ACTIVE - BOX_SIZE), .STEP(BOX_STEP)) u_axis_y (
    .clock (clock),
    .reset (reset),
    .step  (bus.frame_start),
    .pos   (box_y)
  );

  assign x_ext = {1'b0, bus.x};
  assign y_ext = {1'b0, bus.y};

  // Bar boundaries fold to constants at elaboration, so this is a compare chain rather than a divide
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (int'(bus.x) >= (k * H_ACTIVE) / 8) bar_idx = 3'(k);
    end
  end

  assign box_hit = (x_ext >= {1'b0, box_x}) && (x_ext < {1'b0, box_x} + 11'(BOX_SIZE)) &&
                   (y_ext >= {1'b0, box_y}) && (y_ext < {1'b0, box_y} + 11'(BOX_SIZE));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_x      <= '0;
      s1_y      <= '0;
      s1_active <= 1'b0;
      s1_mode   <= BARS;
      s1_bar    <= '0;
      s1_check  <= 1'b0;
      s1_hit    <= 1'b0;
    end else if (bus.pixel_en) begin
      s1_x      <= bus.x;
      s1_y      <= bus.y;
      s1_active <= bus.active;
      s1_mode   <= mode_q;
      s1_bar    <= bar_idx;
      s1_check  <= bus.x[CHECK_LOG2] ^ bus.y[CHECK_LOG2];
      s1_hit    <= box_hit;
    end
  end

  always_comb begin
    colour = COL_BLACK;
    case (s1_mode)
      BARS:     colour = bar_colour(s1_bar);
      GRADIENT: colour = {s1_x[9:2], s1_y[8:1], 8'(({1'b0, s1_x} + {1'b0, s1_y}) >> 3)};
      CHECKER:  colour = s1_check ? COL_WHITE : COL_BLACK;
      BOX:      colour = s1_hit ? COL_RED : COL_BOX_BG;
      default:  colour = COL_BLACK;
    endcase
    if (!s1_active) colour = COL_BLACK;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else if (bus.pixel_en) begin
      r_q     <= colour[23:16];
      g_q     <= colour[15:8];
      b_q     <= colour[7:0];
      valid_q <= s1_active;
    end
  end

  assign bus.R     = r_q;
  assign bus.G     = g_q;
  assign bus.B     = b_q;
  assign bus.valid = valid_q;
  assign bus.mode  = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: expected pixels queued at strobe time, compared two strobes later.
module tb_vga_pattern_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;

  vga_pattern_gen_if vif ();

  vga_pattern_gen dut (
    .clock (clock),
    .reset (reset),
    .bus   (vif)
  );

  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  int          frames = 0;
  logic [24:0] sb[$];
  logic [24:0] exp_pix;

  // Output for strobe n belongs to the pixel pushed at strobe n-1
  always @(posedge clock) begin
    if (vif.pixel_en && !reset) begin
      #1;
      if (sb.size() >= 2) begin
        exp_pix = sb.pop_front();
        checks++;
        if ({vif.R, vif.G, vif.B, vif.valid} !== exp_pix) begin
          errors++;
          $display("[TB] FAIL pixel: got rgb=%h valid=%b, want rgb=%h valid=%b",
                   {vif.R, vif.G, vif.B}, vif.valid, exp_pix[24:1], exp_pix[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic strobe(input logic [9:0] px, input logic [9:0] py, input logic act,
                        input logic [23:0] rgb, input logic fs = 1'b0, input logic mn = 1'b0);
    @(negedge clock);
    vif.x           = px;
    vif.y           = py;
    vif.active      = act;
    vif.pixel_en    = 1'b1;
    vif.frame_start = fs;
    vif.mode_next   = mn;
    sb.push_back({act ? rgb : 24'h000000, act});
    if (fs) frames++;
    @(negedge clock);
    vif.pixel_en    = 1'b0;
    vif.frame_start = 1'b0;
    vif.mode_next   = 1'b0;
  endtask

  task automatic pulse(input logic fs, input logic mn);
    @(negedge clock);
    vif.frame_start = fs;
    vif.mode_next   = mn;
    if (fs) frames++;
    @(negedge clock);
    vif.frame_start = 1'b0;
    vif.mode_next   = 1'b0;
  endtask

  task automatic drain();
    strobe(10'd0, 10'd0, 1'b0, 24'h000000);
    @(negedge clock);
    sb.delete();
  endtask

  task automatic test_reset();
    vif.pixel_en = 1'b0; vif.x = '0; vif.y = '0; vif.active = 1'b0;
    vif.frame_start = 1'b0; vif.mode_next = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({vif.R, vif.G, vif.B, vif.valid, vif.mode} !== 27'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, want 0", {vif.R, vif.G, vif.B, vif.valid, vif.mode});
    end
    reset = 1'b0;
    frames = 0;
    repeat (2) @(negedge clock);
    checks++;
    if ({dut.box_x, dut.box_y} !== 20'd0 || vif.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_box: got x=%0d y=%0d valid=%b, want 0 0 0", dut.box_x, dut.box_y, vif.valid);
    end
  endtask

  task automatic test_bars();
    strobe(10'd0,   10'd10, 1'b1, 24'hFFFFFF);
    strobe(10'd85,  10'd10, 1'b1, 24'hFFFF00);
    strobe(10'd159, 10'd10, 1'b1, 24'hFFFF00);
    strobe(10'd160, 10'd10, 1'b1, 24'h00FFFF);
    strobe(10'd239, 10'd10, 1'b1, 24'h00FFFF);
    strobe(10'd240, 10'd10, 1'b1, 24'h00FF00);
    strobe(10'd320, 10'd10, 1'b1, 24'hFF00FF);
    strobe(10'd399, 10'd10, 1'b1, 24'hFF00FF);
    strobe(10'd400, 10'd10, 1'b1, 24'hFF0000);
    strobe(10'd480, 10'd10, 1'b1, 24'h0000FF);
    strobe(10'd560, 10'd10, 1'b1, 24'h000000);
    strobe(10'd300, 10'd10, 1'b0, 24'h000000);
    strobe(10'd479, 10'd10, 1'b1, 24'hFF0000);
    strobe(10'd100, 10'd10, 1'b1, 24'hFFFF00);
    repeat (4) @(negedge clock);
    checks++;
    if ({vif.R, vif.G, vif.B, vif.valid} !== {24'hFF0000, 1'b1}) begin
      errors++;
      $display("[TB] FAIL hold: got %h/%b, want ff0000/1", {vif.R, vif.G, vif.B}, vif.valid);
    end
    drain();
  endtask

  task automatic test_mode_pending();
    repeat (3) begin
      pulse(1'b0, 1'b1);
      @(negedge clock);
    end
    checks++;
    if (vif.mode !== 2'd0) begin
      errors++;
      $display("[TB] FAIL mode_mid_frame: got %0d, want 0", vif.mode);
    end
    pulse(1'b1, 1'b0);
    checks++;
    if (vif.mode !== 2'd1) begin
      errors++;
      $display("[TB] FAIL mode_advance: got %0d, want 1", vif.mode);
    end
    strobe(10'd100, 10'd50,  1'b1, 24'h191912);
    strobe(10'd639, 10'd479, 1'b1, 24'h9FEF8B);
    strobe(10'd0,   10'd0,   1'b1, 24'h000000);
    strobe(10'd8,   10'd0,   1'b1, 24'h020001);
    drain();
  endtask

  task automatic test_simultaneous();
    strobe(10'd100, 10'd50, 1'b1, 24'h191912, 1'b1, 1'b1);
    strobe(10'd32,  10'd0,  1'b1, 24'hFFFFFF);
    drain();
    checks++;
    if (vif.mode !== 2'd2 || dut.box_x !== 10'd4 || dut.box_y !== 10'd4) begin
      errors++;
      $display("[TB] FAIL simultaneous: got mode=%0d box=(%0d,%0d), want 2 (4,4)", vif.mode, dut.box_x, dut.box_y);
    end
  endtask

  task automatic test_checker();
    strobe(10'd0,  10'd0,  1'b1, 24'h000000);
    strobe(10'd32, 10'd0,  1'b1, 24'hFFFFFF);
    strobe(10'd32, 10'd32, 1'b1, 24'h000000);
    strobe(10'd63, 10'd64, 1'b1, 24'hFFFFFF);
    strobe(10'd31, 10'd31, 1'b1, 24'h000000);
    drain();
  endtask

  task automatic test_box();
    pulse(1'b1, 1'b1);
    checks++;
    if (vif.mode !== 2'd3 || dut.box_x !== 10'd6 || dut.box_y !== 10'd6) begin
      errors++;
      $display("[TB] FAIL box_setup: got mode=%0d box=(%0d,%0d), want 3 (6,6)", vif.mode, dut.box_x, dut.box_y);
    end
    strobe(10'd6,  10'd6,  1'b1, 24'hFF0000);
    strobe(10'd5,  10'd6,  1'b1, 24'h000040);
    strobe(10'd38, 10'd6,  1'b1, 24'h000040);
    strobe(10'd37, 10'd37, 1'b1, 24'hFF0000);
    strobe(10'd6,  10'd38, 1'b1, 24'h000040);
    strobe(10'd6,  10'd5,  1'b1, 24'h000040);
    drain();
  endtask

  task automatic test_no_advance();
    pulse(1'b1, 1'b0);
    checks++;
    if (vif.mode !== 2'd3) begin
      errors++;
      $display("[TB] FAIL no_advance: got mode=%0d, want 3", vif.mode);
    end
    strobe(10'd6,  10'd6,  1'b1, 24'h000040);
    strobe(10'd8,  10'd8,  1'b1, 24'hFF0000);
    strobe(10'd39, 10'd39, 1'b1, 24'hFF0000);
    strobe(10'd40, 10'd8,  1'b1, 24'h000040);
    drain();
  endtask

  task automatic test_bounce();
    while (frames < 224) pulse(1'b1, 1'b0);
    checks++;
    if (dut.box_y !== 10'd448 || dut.box_x !== 10'd448) begin
      errors++;
      $display("[TB] FAIL bounce_y_limit: got box=(%0d,%0d), want (448,448)", dut.box_x, dut.box_y);
    end
    pulse(1'b1, 1'b0);
    checks++;
    if (dut.box_y !== 10'd446 || dut.box_x !== 10'd450) begin
      errors++;
      $display("[TB] FAIL bounce_y_back: got box=(%0d,%0d), want (450,446)", dut.box_x, dut.box_y);
    end
    while (frames < 304) pulse(1'b1, 1'b0);
    checks++;
    if (dut.box_x !== 10'd608 || dut.u_axis_x.dir !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bounce_x_limit: got x=%0d dir=%b, want 608 0", dut.box_x, dut.u_axis_x.dir);
    end
    pulse(1'b1, 1'b0);
    checks++;
    if (dut.box_x !== 10'd606) begin
      errors++;
      $display("[TB] FAIL bounce_x_back: got x=%0d, want 606", dut.box_x);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clock);
    reset = 1'b1;
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    frames = 0;
    strobe(10'd0, 10'd0, 1'b1, 24'hFFFFFF);
    checks++;
    if ({vif.R, vif.G, vif.B, vif.valid} !== 25'd0) begin
      errors++;
      $display("[TB] FAIL pipe_cleared: got %h/%b, want 000000/0", {vif.R, vif.G, vif.B}, vif.valid);
    end
    strobe(10'd85, 10'd0, 1'b1, 24'hFFFF00);
    drain();
    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b1);
    while (frames < 50) pulse(1'b1, 1'b0);
    checks++;
    if (vif.mode !== 2'd2 || dut.box_x !== 10'd100 || dut.box_y !== 10'd100) begin
      errors++;
      $display("[TB] FAIL mid_reset_setup: got mode=%0d box=(%0d,%0d), want 2 (100,100)", vif.mode, dut.box_x, dut.box_y);
    end
    strobe(10'd32, 10'd0, 1'b1, 24'hFFFFFF);
    strobe(10'd32, 10'd0, 1'b1, 24'hFFFFFF);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({vif.R, vif.G, vif.B, vif.valid, vif.mode} !== 27'd0 || {dut.box_x, dut.box_y} !== 20'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got rgb=%h valid=%b mode=%0d box=(%0d,%0d), want all 0",
               {vif.R, vif.G, vif.B}, vif.valid, vif.mode, dut.box_x, dut.box_y);
    end
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bars();
    test_mode_pending();
    test_simultaneous();
    test_checker();
    test_box();
    test_no_advance();
    test_bounce();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Pixel source that sits directly upstream of the VGADriver stage and feeds its 8-bit R/G/B inputs.
- Takes the current pixel coordinate, active flag, pixel-clock enable and frame-start strobe.
- Produces one of four selectable test patterns, with a fixed 2-pixel pipeline latency.
- Used for bring-up of the VGA output path on the board before any framebuffer exists.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.
- BOX_SIZE, 32, side length in pixels of the bouncing box.
- BOX_STEP, 2, box displacement per frame on each axis.
- CHECK_LOG2, 5, log2 of the checkerboard square size.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pixel_en  in  1  single-cycle strobe, one per pixel; pipeline advances only when high.
- x  in  10  horizontal pixel coordinate, valid with pixel_en.
- y  in  10  vertical pixel coordinate, valid with pixel_en.
- active  in  1  coordinate lies in the visible area.
- frame_start  in  1  single-cycle pulse at the start of each frame.
- mode_next  in  1  single-cycle request to advance to the next pattern.
- R  out  8  red component.
- G  out  8  green component.
- B  out  8  blue component.
- valid  out  1  R/G/B correspond to an active pixel.
- mode  out  2  currently displayed pattern, for debug LEDs.

Behaviour:
- Reset (asynchronous): R=G=B=0, valid=0, mode=BARS (0), pending=0. Box position (0,0), both directions positive. Pipeline registers cleared. Reset mid-frame has immediate effect; there is no resynchronisation state.
- Mode FSM cycles BARS(0) -> GRADIENT(1) -> CHECKER(2) -> BOX(3) -> BARS.
  - mode_next sets a pending flag; any number of presses within one frame advance the mode by exactly one.
  - On frame_start with pending set, or with mode_next high in the same cycle, mode advances and pending clears.
  - The mode never changes mid-frame.
- Pipeline stage 1 (on pixel_en): register x, y, active and mode; compute bar index, checker bit and box-hit flag.
- Pipeline stage 2 (on pixel_en): register the colour.
  - Outputs reflect the coordinate presented two pixel_en strobes earlier.
  - Outputs hold between strobes.
- Inactive pixels: R=G=B=0 and valid=0.
- BARS: bar k spans x in [k*H_ACTIVE/8, (k+1)*H_ACTIVE/8); boundaries are elaborate-time constants, no divider. Colours for k=0..7:
  - white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00
  - magenta FF00FF, red FF0000, blue 0000FF, black 000000
- GRADIENT: R = x>>2 (low 8 bits); G = y>>1 (low 8 bits); B = ((x+y)>>3) low 8 bits, with x+y computed at 11 bits.
- CHECKER: bit0 of ((x>>CHECK_LOG2) xor (y>>CHECK_LOG2)); 1 gives FFFFFF, 0 gives 000000.
- BOX: pixel inside [box_x, box_x+BOX_SIZE) x [box_y, box_y+BOX_SIZE) gives FF0000; otherwise 000040.
- Box motion:
  - Position updates on every frame_start regardless of mode; each axis is independent.
  - Positive direction: if pos+BOX_STEP >= LIMIT (LIMIT = H_ACTIVE-BOX_SIZE or V_ACTIVE-BOX_SIZE), pos=LIMIT and direction flips; else pos += BOX_STEP.
  - Negative direction: if pos <= BOX_STEP, pos=0 and direction flips; else pos -= BOX_STEP.
  - Position never leaves [0, LIMIT].
- Simultaneous frame_start and pixel_en:
  - The pixel uses the box position and mode from before the update.
  - The new values apply from the next strobe.

Decomposition:
- Package vga_pkg holds:
  - mode enum (BARS, GRADIENT, CHECKER, BOX) and 24-bit colour constants;
  - defaults shared with VGADriver: H_ACTIVE, V_ACTIVE.
- One sub-module, vga_bounce_axis, parameterised by LIMIT and STEP. It holds pos and dir with the saturate-and-flip rule and is instantiated once per axis.

Test Plan:
- Reset, mode BARS, active=1, x=0 then x=85, y=10 -> after 2 strobes FFFFFF, next strobe FFFF00, valid=1. With active=0, outputs 000000 and valid=0.
- mode_next pulsed 3 times mid-frame, then frame_start -> mode goes 0->1 only. At x=100, y=50: R=0x19, G=0x19, B=0x12.
- Mode CHECKER: (0,0) -> 000000; (32,0) -> FFFFFF; (32,32) -> 000000.
- Mode BOX, 3 frame_starts after reset -> box at (6,6). Pixel (6,6) -> FF0000; (5,6) -> 000040; (38,6) -> 000040.
- 304 frame_starts -> box_x=608 with dir_x flipped; 305th -> box_x=606. Separately, 224 frames -> box_y=448; 225th -> 446.
- Assert reset mid-frame with mode=2 and box at (100,100) -> outputs 0, mode 0 and box (0,0) immediately, before the next clock edge.
